uart_loader: RTL
================

UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, sets the memory byte address of the first loaded word.
REQ-002 Parameter MAX_WORDS, default 4096, sets the largest accepted word count.
REQ-003 clk_i  in  1  single clock; all flops on its rising edge.
REQ-004 rst_i  in  1  reset; asynchronous and active-low.
REQ-005 start_i  in  1  one-cycle pulse that begins a load session.
REQ-006 hs_read_o, hs_write_o  out  1 each  UART handshake read/write strobes.
REQ-007 hs_addr_o  out  5  UART register byte address: 0x00 RX data, 0x04 TX data, 0x08 status.
REQ-008 hs_data_o  out  8  UART write data.
REQ-009 hs_ready_i  in  1  UART access accepted.
REQ-010 hs_data_i  in  8  UART read data, valid in the accept cycle.
REQ-011 mem_we_o  out  1  memory write request.
REQ-012 mem_addr_o  out  32  memory byte address.
REQ-013 mem_wdata_o  out  32  memory write data.
REQ-014 mem_ready_i  in  1  memory write accepted.
REQ-015 busy_o, done_o, error_o  out  1 each  session status flags.

Function
REQ-016 An access completes in any cycle where the strobe and hs_ready_i are both 1; hs_data_i is sampled in that same cycle.
REQ-017 At most one of hs_read_o and hs_write_o is asserted in any cycle.
REQ-018 The state machine has states IDLE, POLL, READ, SETTLE, STORE, TXPOLL, TXWRITE, DONE and ERROR.
REQ-019 IDLE: on start_i, clear done_o and error_o, clear the byte/word counters, go to POLL; start_i outside IDLE/DONE/ERROR is ignored.
REQ-020 POLL: read 0x08; if bit6 (frame error) or bit5 (overrun) is set, go to ERROR; otherwise if bit0 (RX not empty) is set, go to READ; otherwise stay in POLL.
REQ-021 READ: read 0x00 (this pops the RX FIFO) and shift the byte into the word assembler, little-endian; then go to SETTLE.
REQ-022 SETTLE: one idle cycle so the next status read reflects the pop; the next state follows REQ-023 to REQ-025.
REQ-023 Header phase: the first 4 bytes form the word count N; if N > MAX_WORDS, go to ERROR; if N == 0, go to TXPOLL.
REQ-024 Data phase: after every 4th payload byte, go to STORE; otherwise go to POLL.
REQ-025 STORE: hold mem_we_o=1 with mem_addr_o=BASE_ADDR+4*k and mem_wdata_o stable until mem_ready_i; after word N-1, go to the end phase; otherwise go to POLL.
REQ-026 Address arithmetic is 32-bit modulo 2^32 (wrap-around permitted); k is a 13-bit count.
REQ-027 TXPOLL: read 0x08; when bit3 (TX full) is 0, go to TXWRITE.
REQ-028 TXWRITE: write the response byte to 0x04, then go to DONE (or to ERROR after a NAK).
REQ-029 busy_o = 1 in every state except IDLE, DONE and ERROR; done_o is set on entry to DONE; error_o is set on entry to ERROR.
REQ-030 done_o and error_o stay set until the next start_i; DONE and ERROR behave like IDLE for start_i.

Reset
REQ-031 Asserting rst_i, including mid-session, forces IDLE immediately; all strobes, mem_we_o, busy_o, done_o and error_o go to 0, and addresses, data and counters go to 0.
REQ-032 A session in progress when reset is asserted is abandoned and is not resumed after reset.

Configuration
REQ-033 Macro UART_LOADER_CHECKSUM_EN defined: after the last word, one more byte is read and compared with the XOR of all payload bytes (header excluded); match sends ACK 0x06 and goes to DONE, mismatch sends NAK 0x15 and goes to ERROR.
REQ-034 Macro undefined: no checksum byte is read and ACK 0x06 is always sent after the last word.

Structure
REQ-035 Package uart_loader_pkg holds the state encoding, the UART register offsets (0x00/0x04/0x08), the status bit indices (0, 3, 5, 6) and ACK/NAK constants.
REQ-036 A sub-module uart_loader_packer holds the byte-to-word shift register, byte count and running XOR; the FSM lives in uart_loader.

Verification
REQ-037 Header 01 00 00 00, payload 13 00 00 00 with BASE_ADDR=0x100 -> one write of 0x00000013 at 0x100, TX 0x06, done_o=1.
REQ-038 Header N=3 with mem_ready_i delayed 5 cycles each -> writes at BASE, BASE+4, BASE+8, each held stable until accepted.
REQ-039 Header N=5000 -> error_o=1, no memory writes, no TX write.
REQ-040 Status bit6 set during payload -> ERROR with no further memory writes.
REQ-041 With UART_LOADER_CHECKSUM_EN, N=1, payload AA 55 00 FF, checksum 0x00 -> ACK 0x06; checksum 0x01 -> NAK 0x15 and error_o=1.
REQ-042 rst_i asserted mid-payload, then start_i pulsed -> clean restart: first write lands at BASE_ADDR.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART boot loader: FSM state encoding, load
// phases, UART register map, status bit positions and response bytes.
package uart_loader_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        POLL    = 4'd1,
        READ    = 4'd2,
        SETTLE  = 4'd3,
        STORE   = 4'd4,
        TXPOLL  = 4'd5,
        TXWRITE = 4'd6,
        DONE    = 4'd7,
        ERROR   = 4'd8
    } state_t;

    // Which part of the byte stream the next received byte belongs to.
    typedef enum logic [1:0] {
        PH_HEADER  = 2'd0,
        PH_PAYLOAD = 2'd1,
        PH_CHECK   = 2'd2
    } phase_t;

    localparam logic [4:0] REG_RX     = 5'h00;
    localparam logic [4:0] REG_TX     = 5'h04;
    localparam logic [4:0] REG_STATUS = 5'h08;

    localparam int ST_RX_NE   = 0;
    localparam int ST_TX_FULL = 3;
    localparam int ST_OVERRUN = 5;
    localparam int ST_FRAME   = 6;

    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    // A receive-side fault is either a framing error or an overrun.
    function automatic logic status_error(input logic [7:0] status);
        return status[ST_FRAME] | status[ST_OVERRUN];
    endfunction

endpackage

// File: rtl/uart_loader_packer.sv
// Byte-to-word assembler for the loader: little-endian shift register,
// modulo-4 byte count and running XOR of the payload bytes.
module uart_loader_packer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr,
    input  logic        shift,
    input  logic        xor_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic [1:0]  byte_cnt,
    output logic [7:0]  csum
);

    // New bytes enter at the top so the first byte of a group ends in [7:0].
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            word     <= '0;
            byte_cnt <= '0;
            csum     <= '0;
        end else if (clr) begin
            word     <= '0;
            byte_cnt <= '0;
            csum     <= '0;
        end else if (shift) begin
            word     <= {byte_in, word[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (xor_en) begin
                csum <= csum ^ byte_in;
            end
        end
    end

endmodule

// File: rtl/uart_loader.sv
// UART boot loader: polls a UART, reads a 32-bit little-endian word count
// followed by that many payload words, writes them to memory from BASE_ADDR
// upward and answers with ACK/NAK on the UART TX register.
// Optional feature: define UART_LOADER_CHECKSUM_EN to read a trailing XOR
// checksum byte after the payload and answer NAK on mismatch.
// Handshakes: a UART access completes in a cycle where its strobe and
// hs_ready_i are both 1 (read data sampled in that cycle); a memory write
// completes in a cycle where mem_we_o and mem_ready_i are both 1, and address
// and data stay constant until then. state_o exposes the FSM state for debug.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 4096
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        hs_read_o,
    output logic        hs_write_o,
    output logic [4:0]  hs_addr_o,
    output logic [7:0]  hs_data_o,
    input  logic        hs_ready_i,
    input  logic [7:0]  hs_data_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [3:0]  state_o
);

    state_t      state, next;
    phase_t      phase;
    logic [12:0] k;
    logic [31:0] n;
    logic        nak;
    logic [31:0] word;
    logic [1:0]  byte_cnt;
    logic [7:0]  csum;
    logic        start_ok;
    logic        last_word;

    assign start_ok  = start_i && (state == IDLE || state == DONE || state == ERROR);
    assign last_word = ({19'd0, k} == n - 32'd1);

    uart_loader_packer u_packer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr      (start_ok),
        .shift    (state == READ && hs_ready_i),
        .xor_en   (phase == PH_PAYLOAD),
        .byte_in  (hs_data_i),
        .word     (word),
        .byte_cnt (byte_cnt),
        .csum     (csum)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    // Session bookkeeping: phase, word index, word count and NAK flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            phase <= PH_HEADER;
            k     <= '0;
            n     <= '0;
            nak   <= 1'b0;
        end else if (start_ok) begin
            phase <= PH_HEADER;
            k     <= '0;
            n     <= '0;
            nak   <= 1'b0;
        end else if (state == SETTLE) begin
            if (phase == PH_HEADER && byte_cnt == 2'd0) begin
                n     <= word;
                phase <= PH_PAYLOAD;
            end else if (phase == PH_CHECK) begin
                // The checksum byte was the last one shifted into the top lane.
                nak <= (word[31:24] != csum);
            end
        end else if (state == STORE && mem_ready_i) begin
            k <= k + 13'd1;
            if (last_word) begin
                phase <= PH_CHECK;
            end
        end
    end

    // Next-state and output decode; all outputs idle at zero.
    always_comb begin
        next        = state;
        hs_read_o   = 1'b0;
        hs_write_o  = 1'b0;
        hs_addr_o   = REG_RX;
        hs_data_o   = 8'h00;
        mem_we_o    = 1'b0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start_i) next = POLL;
            end
            POLL: begin
                hs_read_o = 1'b1;
                hs_addr_o = REG_STATUS;
                if (hs_ready_i) begin
                    if (status_error(hs_data_i))  next = ERROR;
                    else if (hs_data_i[ST_RX_NE]) next = READ;
                end
            end
            READ: begin
                hs_read_o = 1'b1;
                hs_addr_o = REG_RX;
                if (hs_ready_i) next = SETTLE;
            end
            SETTLE: begin
                case (phase)
                    PH_HEADER: begin
                        if (byte_cnt != 2'd0)              next = POLL;
                        else if (word > 32'(MAX_WORDS))    next = ERROR;
                        else if (word == 32'd0)            next = TXPOLL;
                        else                               next = POLL;
                    end
                    PH_PAYLOAD: next = (byte_cnt == 2'd0) ? STORE : POLL;
                    default:    next = TXPOLL;
                endcase
            end
            STORE: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = BASE_ADDR + {17'd0, k, 2'b00};
                mem_wdata_o = word;
                if (mem_ready_i) begin
`ifdef UART_LOADER_CHECKSUM_EN
                    next = POLL;
`else
                    next = last_word ? TXPOLL : POLL;
`endif
                end
            end
            TXPOLL: begin
                hs_read_o = 1'b1;
                hs_addr_o = REG_STATUS;
                if (hs_ready_i && !hs_data_i[ST_TX_FULL]) next = TXWRITE;
            end
            TXWRITE: begin
                hs_write_o = 1'b1;
                hs_addr_o  = REG_TX;
                hs_data_o  = nak ? NAK : ACK;
                if (hs_ready_i) next = nak ? ERROR : DONE;
            end
            default: next = IDLE;
        endcase
    end

    assign busy_o  = !(state == IDLE || state == DONE || state == ERROR);
    assign done_o  = (state == DONE);
    assign error_o = (state == ERROR);
    assign state_o = state;

endmodule
